// File: rtl/register_file.sv
// Two-read / one-write register file with r0 hardwired to zero.
// Reads are combinational and see a same-cycle write (write-before-read).
module register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2
);

  localparam int NREG = 2 ** ADDR_W;

  // r0 has no storage; only r1..rN-1 exist
  logic [DATA_W-1:0] regs [1:NREG-1];

  logic wr_en;

  assign wr_en = reg_write && (write_reg != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[write_reg] <= write_data;
    end
  end

  function automatic logic [DATA_W-1:0] rd_port(
    input logic [ADDR_W-1:0] a
  );
    logic [DATA_W-1:0] d;
    if (reset || a == '0) begin
      d = '0;
    end else if (wr_en && a == write_reg) begin
      d = write_data;
    end else begin
      d = regs[a];
    end
    return d;
  endfunction

  always_comb begin
    read_data1 = rd_port(read_reg1);
    read_data2 = rd_port(read_reg2);
  end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed bench for register_file with an array model
// and a queue-based scoreboard drained by a negedge monitor.
module tb_register_file;

  logic        clk;
  logic        reset;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  logic        probe;
  int          n_cmp;
  int          n_bad;

  logic [31:0] model [32];
  string       q_nm [$];
  logic [31:0] q1 [$];
  logic [31:0] q2 [$];

  register_file #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk(clk),
    .reset(reset),
    .reg_write(reg_write),
    .write_reg(write_reg),
    .write_data(write_data),
    .read_reg1(read_reg1),
    .read_reg2(read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // What a read of address a must return given this cycle's inputs
  function automatic logic [31:0] ref_rd(
    input logic r, input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [4:0] a
  );
    if (r) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (we && wa == a) return wd;
    return model[a];
  endfunction

  task automatic cyc(
    input logic r, input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [4:0] a1,
    input logic [4:0] a2, input bit chk, input string nm
  );
    reset      = r;
    reg_write  = we;
    write_reg  = wa;
    write_data = wd;
    read_reg1  = a1;
    read_reg2  = a2;
    probe      = chk;
    if (chk) begin
      q_nm.push_back(nm);
      q1.push_back(ref_rd(r, we, wa, wd, a1));
      q2.push_back(ref_rd(r, we, wa, wd, a2));
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 5'd0) begin
      model[wa] = wd;
    end
    #1;
    probe = 1'b0;
  endtask

  always @(negedge clk) begin
    if (probe) begin
      n_cmp++;
      if (q1.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: got %h/%h required an entry",
                 read_data1, read_data2);
      end else begin
        string       nm;
        logic [31:0] e1;
        logic [31:0] e2;
        nm = q_nm.pop_front();
        e1 = q1.pop_front();
        e2 = q2.pop_front();
        if (read_data1 !== e1 || read_data2 !== e2) begin
          n_bad++;
          $display("FAIL %s: a1=%0d a2=%0d got %h/%h required %h/%h",
                   nm, read_reg1, read_reg2,
                   read_data1, read_data2, e1, e2);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    probe = 1'b0;
    reset = 1'b0;
    reg_write = 1'b0;
    write_reg = '0;
    write_data = '0;
    read_reg1 = '0;
    read_reg2 = '0;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    @(posedge clk);
    #1;

    // Reset wins over a simultaneous write; bypass is off during reset
    cyc(1, 1, 5, 32'hDEAD_BEEF, 5, 5, 1, "rst_bypass_off");
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, "post_rst_zero");

    cyc(0, 1, 8, 32'h0000_1234, 0, 0, 1, "wr8");
    cyc(0, 0, 0, 0, 8, 9, 1, "rd8_rd9");

    cyc(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 1, "r0_same");
    cyc(0, 0, 0, 0, 0, 0, 1, "r0_next");

    cyc(0, 1, 3, 32'h1, 0, 0, 0, "");
    cyc(0, 1, 3, 32'h2, 3, 3, 1, "bypass_both");
    cyc(0, 0, 0, 0, 3, 3, 1, "bypass_after");

    cyc(0, 1, 4, 32'h7, 0, 0, 0, "");
    cyc(0, 0, 4, 32'hAAAA_AAAA, 4, 4, 1, "wr_dis_same");
    cyc(0, 0, 0, 0, 4, 3, 1, "wr_dis_hold");

    for (int i = 1; i < 32; i++)
      cyc(0, 1, 5'(i), 32'h100 + i, 5'(i), 0, 1, "sweep_wr");
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, "sweep_rd");

    for (int i = 1; i <= 10; i++)
      cyc(0, 1, 5'(i), 32'h200 + i, 0, 0, 0, "");
    cyc(1, 0, 0, 0, 10, 1, 1, "midsweep_rst");
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, "midsweep_zero");

    for (int n = 0; n < 600; n++) begin
      logic        r;
      logic        we;
      logic [4:0]  wa;
      logic [4:0]  a1;
      logic [4:0]  a2;
      r  = ($urandom_range(0, 39) == 0);
      we = $urandom_range(0, 1) == 1;
      wa = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
      cyc(r, we, wa, $urandom, a1, a2, 1, "random");
    end

    cyc(0, 0, 0, 0, 0, 0, 0, "");
    if (q1.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d left required 0",
               q1.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
